// File: rtl/dffr_check_ctrl.sv
// dffr_check_ctrl
//   Self-checking sequencer for the resettable D flip-flop cell (dffr_b).
//   It resets the cell, checks that Q=0 and Q-bar=1 after reset, and then
//   applies a deterministic data pattern. Two known bits (1, 0) come first,
//   followed by LFSR bits. Each applied bit is compared against out/outb two
//   edges after it is driven.
//
// Ports
//   clk       in   system clock, all updates on posedge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse, starts a run from IDLE or DONE
//   dut_rst   out  active-low reset to the cell under test (registered)
//   dut_data  out  data to the cell under test (registered)
//   dut_out   in   cell Q
//   dut_outb  in   cell Q-bar
//   busy      out  high in RESET, CHK_RST, LOAD, DRAIN
//   done      out  high in DONE until the next start
//   pass      out  valid with done, 1 iff err_cnt == 0
//   err_cnt   out  saturating mismatch count for the current run
//   phase     out  state encoding (IDLE=0 .. DONE=5)
module dffr_check_ctrl #(
    parameter int unsigned RST_CYC = 3,
    parameter int unsigned PAT_LEN = 16,
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_rst,
    output logic             dut_data,
    input  logic             dut_out,
    input  logic             dut_outb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_CHK_RST = 3'd2,
        S_LOAD    = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               dut_rst_q, dut_rst_d;
    logic               dut_data_q, dut_data_d;
    logic [ERR_W-1:0]   err_q, err_d;
    // Expected-value pipeline: stage 1 is written when a bit is driven,
    // stage 2 is compared against the cell one edge after it captures.
    logic               p1_v_q, p1_v_d, p1_b_q, p1_b_d;
    logic               p2_v_q, p2_v_d, p2_b_q, p2_b_d;

    logic               start_ok;
    logic               pat_bit;
    logic               mis_chk;
    logic               mis_pipe;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lfsr_q     <= SEED;
            dut_rst_q  <= 1'b0;
            dut_data_q <= 1'b0;
            err_q      <= '0;
            p1_v_q     <= 1'b0;
            p1_b_q     <= 1'b0;
            p2_v_q     <= 1'b0;
            p2_b_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            dut_rst_q  <= dut_rst_d;
            dut_data_q <= dut_data_d;
            err_q      <= err_d;
            p1_v_q     <= p1_v_d;
            p1_b_q     <= p1_b_d;
            p2_v_q     <= p2_v_d;
            p2_b_q     <= p2_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            end
            S_RESET: begin
                if (cnt_q == 16'(RST_CYC - 1)) begin
                    state_d = S_CHK_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CHK_RST: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            S_LOAD: begin
                if (cnt_q == 16'(PAT_LEN - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                // Two cycles let the last two driven bits reach the compare.
                if (cnt_q == 16'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: stimulus, expected pipeline, error counter
    // ------------------------------------------------------------------
    always_comb begin
        if (cnt_q == 16'd0) begin
            pat_bit = 1'b1;
        end else if (cnt_q == 16'd1) begin
            pat_bit = 1'b0;
        end else begin
            pat_bit = lfsr_q[0];
        end
    end

    // Case inequality makes x/z on the cell outputs a mismatch.
    assign mis_chk  = (state_q == S_CHK_RST) &&
                      ((dut_out !== 1'b0) || (dut_outb !== 1'b1));
    assign mis_pipe = p2_v_q &&
                      ((dut_out !== p2_b_q) || (dut_outb !== ~p2_b_q));

    always_comb begin
        lfsr_d     = lfsr_q;
        dut_rst_d  = (state_d != S_RESET);
        dut_data_d = dut_data_q;
        err_d      = err_q;
        p1_v_d     = 1'b0;
        p1_b_d     = 1'b0;
        p2_v_d     = p1_v_q;
        p2_b_d     = p1_b_q;

        if (state_q == S_LOAD) begin
            dut_data_d = pat_bit;
            p1_v_d     = 1'b1;
            p1_b_d     = pat_bit;
            if (cnt_q >= 16'd2) begin
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
            end
        end else if (state_d inside {S_IDLE, S_RESET, S_CHK_RST}) begin
            dut_data_d = 1'b0;
        end

        if ((mis_chk || mis_pipe) && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end

        if (start_ok) begin
            lfsr_d = SEED;
            err_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q == S_RESET) || (state_q == S_CHK_RST) ||
                   (state_q == S_LOAD)  || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
        pass     = (state_q == S_DONE) && (err_q == '0);
        phase    = state_q;
        dut_rst  = dut_rst_q;
        dut_data = dut_data_q;
        err_cnt  = err_q;
    end

endmodule

// File: tb/tb_dffr_check_ctrl.sv
// Testbench for dffr_check_ctrl. A behavioural dffr_b cell model with
// selectable faults drives dut_out/dut_outb. A second instance with
// ERR_W=2 watches a stuck-at-0 cell to exercise counter saturation.
module tb_dffr_check_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic       dut_rst, dut_data, dut_out, dut_outb;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [2:0] phase;

    logic       dut_rst2, dut_data2, busy2, done2, pass2;
    logic       dut_out2, dut_outb2;
    logic [1:0] err_cnt2;
    logic [2:0] phase2;

    // Cell fault: 0 good, 1 Q stuck 0, 2 reset forces Q=1, 3 outb == out
    int         fault = 0;
    logic       cell_q;

    int         checks = 0;
    int         errors = 0;
    bit         exp_q[$];

    logic [15:0] seq_ref, seq_b, seq_c, pat;

    dffr_check_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_rst(dut_rst), .dut_data(dut_data),
        .dut_out(dut_out), .dut_outb(dut_outb),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .phase(phase)
    );

    dffr_check_ctrl #(.ERR_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start),
        .dut_rst(dut_rst2), .dut_data(dut_data2),
        .dut_out(dut_out2), .dut_outb(dut_outb2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .phase(phase2)
    );

    always @(posedge clk or negedge dut_rst) begin
        if (!dut_rst) cell_q <= (fault == 2);
        else          cell_q <= dut_data;
    end
    assign dut_out   = (fault == 1) ? 1'b0 : cell_q;
    assign dut_outb  = (fault == 3) ? dut_out : ~cell_q;
    assign dut_out2  = 1'b0;
    assign dut_outb2 = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] gen_pattern();
        logic [7:0]  l = 8'hA5;
        logic [15:0] p = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      p[i] = 1'b1;
            else if (i == 1) p[i] = 1'b0;
            else begin
                p[i] = l[0];
                l = {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
            end
        end
        return p;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_phase"},   32'(phase),    0);
        check({tag, "_dut_rst"}, 32'(dut_rst),  0);
        check({tag, "_dut_data"},32'(dut_data), 0);
        check({tag, "_busy"},    32'(busy),     0);
        check({tag, "_done"},    32'(done),     0);
        check({tag, "_pass"},    32'(pass),     0);
        check({tag, "_err"},     32'(err_cnt),  0);
    endtask

    // One full run: expected bits are queued when start is driven and
    // popped as each LOAD bit appears on dut_data.
    task automatic run_once(input bit glitch, output logic [15:0] seq);
        logic [15:0] p = gen_pattern();
        int          busy_cyc = 0;
        int          n = 0;
        int          lcnt = 0;
        int          idx = 0;
        logic [2:0]  prev_ph;
        bit          e;
        seq = '0;
        for (int i = 0; i < 16; i++) exp_q.push_back(p[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clr_err",  32'(err_cnt), 0);
        check("start_clr_done", 32'(done),    0);
        prev_ph = phase;
        while (n < 200 && done !== 1'b1) begin
            if (busy === 1'b1) busy_cyc++;
            if (prev_ph == 3'd3) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("dut_data", 32'(dut_data), 32'(e));
                end
                if (idx < 16) seq[idx] = dut_data;
                idx++;
            end
            prev_ph = phase;
            if (glitch && phase == 3'd3) lcnt++;
            start = glitch && (lcnt == 4);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("run_done",    32'(done),         1);
        check("busy_cycles", 32'(busy_cyc),     22);
        check("sb_drained",  32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        int lcnt;
        rst   = 1'b0;
        start = 1'b0;
        pat   = gen_pattern();
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        @(negedge clk);
        check("idle_dut_rst", 32'(dut_rst), 1);
        check("idle_phase",   32'(phase),   0);

        // Good cell; the ERR_W=2 instance sees a stuck cell alongside.
        fault = 0;
        run_once(1'b0, seq_ref);
        check("good_pass",  32'(pass),     1);
        check("good_err",   32'(err_cnt),  0);
        check("good_bit2",  32'(seq_ref[2]), 1);
        check("sat_done",   32'(done2),    1);
        check("sat_err",    32'(err_cnt2), 3);
        check("sat_pass",   32'(pass2),    0);

        // Start pulsed mid-LOAD is ignored; rerun from DONE is identical.
        run_once(1'b1, seq_b);
        check("rerun_seq",  32'(seq_b),   32'(seq_ref));
        check("rerun_pass", 32'(pass),    1);

        fault = 1;
        run_once(1'b0, seq_c);
        check("stuck0_err",  32'(err_cnt), 32'($countones(pat)));
        check("stuck0_pass", 32'(pass),    0);

        fault = 2;
        run_once(1'b0, seq_c);
        check("norst_err",  32'(err_cnt), 1);
        check("norst_pass", 32'(pass),    0);

        fault = 3;
        run_once(1'b0, seq_c);
        check("outb_eq_err",  32'(err_cnt), 17);
        check("outb_eq_pass", 32'(pass),    0);

        // Reset pulse during LOAD bit 5, then a clean run.
        fault = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        lcnt = 0;
        while (n < 100) begin
            if (phase == 3'd3) lcnt++;
            if (lcnt == 6) break;
            @(negedge clk);
            n++;
        end
        check("reach_load5", 32'(lcnt), 6);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        check("midrst_done_held", 32'(done), 0);
        rst = 1'b1;
        @(negedge clk);
        run_once(1'b0, seq_c);
        check("post_rst_pass", 32'(pass),  1);
        check("post_rst_seq",  32'(seq_c), 32'(seq_ref));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
